load_store_unit: RTL and testbench

Memory-stage executor for the data memory control produced by the instruction decoder. It consumes the store-size code and load flag, plus address, store data and funct3. It turns them into a single-outstanding request/grant/response transaction on the data memory bus, with byte enables and lane-replicated write data. Load data is aligned and sign- or zero-extended back to the pipeline, and the pipeline is stalled while an access is in flight.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 14 +
 rtl/load_store_unit_load_align.sv | 35 +++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } lsu_state_e;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_SB   = 2'b01;
    localparam logic [1:0] MEM_SH   = 2'b10;
    localparam logic [1:0] MEM_SW   = 2'b11;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Byte enables for a store of the given size at the given byte lane.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            MEM_SB:  be = 4'b0001 << lane;
            MEM_SH:  be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory bus: single-outstanding request/grant/response.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load lane selection and sign/zero extension of a 32-bit bus word.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_bytes[lane];
    assign sel_half = lane[1] ? rdata[31:16] : rdata[15:0];
    assign sign_ext = ~funct3[2];

    always_comb begin
        result = rdata;
        if (funct3[1:0] == LD_BYTE) begin
            result = {{24{sel_byte[7] & sign_ext}}, sel_byte};
        end else if (funct3[1:0] == LD_HALF) begin
            result = {{16{sel_half[15] & sign_ext}}, sel_half};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store executor: one outstanding bus access, pipeline stall while in flight.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic [1:0]         data_mem_we_i,
    input  logic               mem_to_reg_i,
    input  logic [2:0]         funct3_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               stall_o,
    output logic               done_o,
    output logic [31:0]        rdata_o,
    output logic               misaligned_o,
    load_store_unit_if.master  mem
);

    lsu_state_e  state_reg, state_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  lane_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] rdata_reg;

    logic        is_store, is_load, access, is_half, is_word, misaligned, accept;
    logic [31:0] wdata_next;
    logic [31:0] aligned_rdata;

    // Store takes priority when the decoder flags both.
    assign is_store = (data_mem_we_i != MEM_NONE);
    assign is_load  = ~is_store & mem_to_reg_i;
    assign access   = is_store | is_load;
    assign is_half  = is_store ? (data_mem_we_i == MEM_SH) : (funct3_i[1:0] == LD_HALF);
    assign is_word  = is_store ? (data_mem_we_i == MEM_SW) : funct3_i[1];

    assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    assign accept     = (state_reg == IDLE) & req_valid_i & access & ~misaligned;

    always_comb begin
        wdata_next = 32'h0;
        case (data_mem_we_i)
            MEM_SB:  wdata_next = {4{wdata_i[7:0]}};
            MEM_SH:  wdata_next = {2{wdata_i[15:0]}};
            MEM_SW:  wdata_next = wdata_i;
            default: wdata_next = 32'h0;
        endcase
    end

    load_align u_load_align (
        .rdata  (mem.rdata),
        .lane   (lane_reg),
        .funct3 (funct3_reg),
        .result (aligned_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (mem.gnt) state_next = we_reg ? DONE : WAIT_R;
            WAIT_R:  if (mem.rvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are captured once at accept and held stable until the next accept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_reg     <= 1'b0;
            addr_reg   <= 32'h0;
            be_reg     <= 4'h0;
            wdata_reg  <= 32'h0;
            lane_reg   <= 2'b00;
            funct3_reg <= 3'b000;
            rdata_reg  <= 32'h0;
        end else begin
            if (accept) begin
                we_reg     <= is_store;
                addr_reg   <= {addr_i[31:2], 2'b00};
                be_reg     <= is_store ? store_be(data_mem_we_i, addr_i[1:0]) : 4'b1111;
                wdata_reg  <= wdata_next;
                lane_reg   <= addr_i[1:0];
                funct3_reg <= funct3_i;
            end
            if ((state_reg == WAIT_R) && mem.rvalid) begin
                rdata_reg <= aligned_rdata;
            end
        end
    end

    assign mem.req   = (state_reg == REQ);
    assign mem.we    = we_reg;
    assign mem.addr  = addr_reg;
    assign mem.be    = be_reg;
    assign mem.wdata = wdata_reg;

    assign done_o       = (state_reg == DONE);
    assign rdata_o      = rdata_reg;
    assign stall_o      = rst_ni & (accept | (state_reg == REQ) | (state_reg == WAIT_R));
    assign misaligned_o = rst_ni & (state_reg == IDLE) & req_valid_i & access & misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus fields/results queued at issue, checked at grant/done.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic [1:0]  data_mem_we;
    logic        mem_to_reg;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall, done, misaligned;
    logic [31:0] rdata;

    load_store_unit_if mem_bus();

    load_store_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid),
        .data_mem_we_i (data_mem_we),
        .mem_to_reg_i  (mem_to_reg),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .done_o        (done),
        .rdata_o       (rdata),
        .misaligned_o  (misaligned),
        .mem           (mem_bus.master)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        if (f3[1]) return d;
        if (f3[0]) begin
            sh = a[1] ? (d >> 16) : d;
            return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        sh = d >> {a[1:0], 3'b000};
        return f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    endfunction

    function automatic exp_t model_req(input logic [1:0] we, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [2:0] f3,
                                       input logic [31:0] bus_rd);
        exp_t e;
        e.we    = (we != 2'b00);
        e.addr  = {a[31:2], 2'b00};
        e.be    = 4'b1111;
        e.wdata = wd;
        e.rdata = model_load(bus_rd, a, f3);
        if (we == 2'b01) begin
            e.be    = 4'b0001 << a[1:0];
            e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else if (we == 2'b10) begin
            e.be    = a[1] ? 4'b1100 : 4'b0011;
            e.wdata = {wd[15:0], wd[15:0]};
        end
        return e;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            req_valid = 1'b0; mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
        end
    endtask

    task automatic do_access(input string name, input logic [1:0] we, input logic m2r,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input int gdly, input int rdly, input logic [31:0] bus_rd);
        exp_t e;
        int   stalls = 0;
        int   want_stalls;
        logic is_ld;
        is_ld = (we == 2'b00);
        want_stalls = 2 + gdly + (is_ld ? 1 + rdly : 0);
        sb_q.push_back(model_req(we, a, wd, f3, bus_rd));
        @(negedge clk_i);
        req_valid = 1'b1; data_mem_we = we; mem_to_reg = m2r; funct3 = f3; addr = a; wdata = wd;
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
        #1;
        chk_eq({name, " accept_req"}, 32'(mem_bus.req), 32'h0);
        chk_eq({name, " accept_mis"}, 32'(misaligned), 32'h0);
        stalls += int'(stall);
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk_i);
            mem_bus.gnt = (i == gdly);
            mem_bus.rvalid = (i != gdly);   // stray rvalid in REQ must be ignored
            mem_bus.rdata = $urandom;
            #1;
            chk_eq({name, " req"}, 32'(mem_bus.req), 32'h1);
            chk_eq({name, " req_we"}, 32'(mem_bus.we), 32'(sb_q[0].we));
            chk_eq({name, " req_addr"}, mem_bus.addr, sb_q[0].addr);
            chk_eq({name, " req_be"}, 32'(mem_bus.be), 32'(sb_q[0].be));
            if (!is_ld) chk_eq({name, " req_wdata"}, mem_bus.wdata, sb_q[0].wdata);
            stalls += int'(stall);
        end
        if (is_ld) begin
            for (int i = 0; i <= rdly; i++) begin
                @(negedge clk_i);
                mem_bus.gnt = (i != rdly);  // stray gnt in WAIT_R must be ignored
                mem_bus.rvalid = (i == rdly);
                mem_bus.rdata = (i == rdly) ? bus_rd : 32'($urandom);
                #1;
                chk_eq({name, " wait_req"}, 32'(mem_bus.req), 32'h0);
                chk_eq({name, " wait_done"}, 32'(done), 32'h0);
                stalls += int'(stall);
            end
        end
        @(negedge clk_i);
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = $urandom;
        #1;
        e = sb_q.pop_front();
        chk_eq({name, " done"}, 32'(done), 32'h1);
        chk_eq({name, " done_stall"}, 32'(stall), 32'h0);
        chk_eq({name, " done_req"}, 32'(mem_bus.req), 32'h0);
        chk_eq({name, " rdata"}, rdata, is_ld ? e.rdata : last_rdata);
        if (is_ld) last_rdata = e.rdata;
        chk_eq({name, " stall_cycles"}, 32'(stalls), 32'(want_stalls));
        $display("txn %s we=%0d addr=%h rdata=%h stalls=%0d", name, we, a, rdata, stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_a;
        // Reset with an aligned store presented: stall must be forced low.
        rst_ni = 1'b0; req_valid = 1'b1; data_mem_we = 2'b11; mem_to_reg = 1'b0;
        funct3 = 3'b010; addr = 32'h100; wdata = 32'h1234_5678;
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_eq("rst stall", 32'(stall), 32'h0);
        chk_eq("rst mis", 32'(misaligned), 32'h0);
        chk_eq("rst req", 32'(mem_bus.req), 32'h0);
        chk_eq("rst addr", mem_bus.addr, 32'h0);
        chk_eq("rst be", 32'(mem_bus.be), 32'h0);
        chk_eq("rst wdata", mem_bus.wdata, 32'h0);
        chk_eq("rst we", 32'(mem_bus.we), 32'h0);
        chk_eq("rst rdata", rdata, 32'h0);
        chk_eq("rst done", 32'(done), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid = 1'b0;

        do_access("SB", 2'b01, 1'b0, 3'b000, 32'h1003, 32'h0000_00A5, 0, 0, 32'h0);
        do_access("LB", 2'b00, 1'b1, 3'b000, 32'h2001, 32'h0, 0, 0, 32'h0000_8000);
        do_access("LBU", 2'b00, 1'b1, 3'b100, 32'h2001, 32'h0, 0, 0, 32'h0000_8000);
        do_access("LH_gnt3", 2'b00, 1'b1, 3'b001, 32'h2002, 32'h0, 3, 0, 32'h8001_1234);
        do_access("SH", 2'b10, 1'b0, 3'b001, 32'h1006, 32'h0000_BEEF, 1, 0, 32'h0);
        do_access("LHU_rv2", 2'b00, 1'b1, 3'b101, 32'h2000, 32'h0, 0, 2, 32'h1234_F00D);
        do_access("SW_prio", 2'b11, 1'b1, 3'b010, 32'h3004, 32'hCAFE_F00D, 0, 0, 32'h0);
        idle(1);

        // Misaligned word store: flagged combinationally, no bus activity.
        @(negedge clk_i);
        req_valid = 1'b1; data_mem_we = 2'b11; mem_to_reg = 1'b0; addr = 32'h3002;
        #1;
        chk_eq("mis flag", 32'(misaligned), 32'h1);
        chk_eq("mis stall", 32'(stall), 32'h0);
        @(negedge clk_i);
        req_valid = 1'b0;
        #1;
        chk_eq("mis req", 32'(mem_bus.req), 32'h0);
        chk_eq("mis flag_clear", 32'(misaligned), 32'h0);
        $display("txn MIS addr=00003002 req=%0d", mem_bus.req);

        // Reset during WAIT_R, then a late rvalid.
        @(negedge clk_i);
        req_valid = 1'b1; data_mem_we = 2'b00; mem_to_reg = 1'b1; funct3 = 3'b010; addr = 32'h4000;
        @(negedge clk_i);
        mem_bus.gnt = 1'b1;
        @(negedge clk_i);
        mem_bus.gnt = 1'b0;
        #1;
        chk_eq("abort wait_stall", 32'(stall), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk_eq("abort rst_stall", 32'(stall), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hDEAD_BEEF;
        #1;
        chk_eq("abort done", 32'(done), 32'h0);
        chk_eq("abort req", 32'(mem_bus.req), 32'h0);
        chk_eq("abort addr", mem_bus.addr, 32'h0);
        chk_eq("abort stall", 32'(stall), 32'h0);
        @(negedge clk_i);
        mem_bus.rvalid = 1'b0;
        #1;
        chk_eq("abort late_done", 32'(done), 32'h0);
        chk_eq("abort rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        $display("txn ABORT done=%0d rdata=%h", done, rdata);

        // Back-to-back: LW presented in the cycle right after the SW's DONE.
        do_access("B2B_SW", 2'b11, 1'b0, 3'b010, 32'h5000, 32'h0BAD_CAFE, 0, 0, 32'h0);
        do_access("B2B_LW", 2'b00, 1'b1, 3'b010, 32'h5000, 32'h0, 0, 0, 32'h0BAD_CAFE);

        for (int i = 0; i < 8; i++) begin
            r_we = 2'($urandom_range(0, 3));
            r_f3 = {1'($urandom), 2'($urandom_range(0, 2))};
            r_a  = {16'h0, 16'($urandom)};
            if (r_we == 2'b10 || (r_we == 2'b00 && r_f3[1:0] == 2'b01)) r_a[0] = 1'b0;
            if (r_we == 2'b11 || (r_we == 2'b00 && r_f3[1])) r_a[1:0] = 2'b00;
            do_access($sformatf("RND%0d", i), r_we, 1'b1, r_f3, r_a, $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            idle($urandom_range(0, 1));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
